// File: rtl/wait_time_entry_pkg.sv
// Shared definitions for the teller keypad wait-time entry block.
//   state_e     : entry FSM encoding (IDLE / ONE / TWO / ERR)
//   BCD_MAX     : largest legal decimal digit
//   MAX_DIGITS  : number of decimal digits an entry may hold
//   RESET_VALUE : committed value after reset
package wait_time_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_TWO  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam int         MAX_DIGITS  = 2;
  localparam logic [7:0] RESET_VALUE = 8'd0;

  // True when the keypad code is a legal decimal digit.
  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/wait_time_entry_if.sv
// Keypad-side bundle of the wait-time entry block.
//   digit_valid/digit : one-cycle digit strobe and BCD code
//   enter / clear     : one-cycle commit / abort strobes
//   value/value_valid : committed binary wait time and its update pulse
//   most_digit/least_digit/digit_count/err : live entry echo and status
// master = keypad / controller side, slave = entry block.
interface wait_time_entry_if #(
  parameter int WIDTH = 8
);
  logic             digit_valid;
  logic [3:0]       digit;
  logic             enter;
  logic             clear;
  logic [WIDTH-1:0] value;
  logic             value_valid;
  logic [3:0]       most_digit;
  logic [3:0]       least_digit;
  logic [1:0]       digit_count;
  logic             err;

  modport master (
    output digit_valid, digit, enter, clear,
    input  value, value_valid, most_digit, least_digit, digit_count, err
  );

  modport slave (
    input  digit_valid, digit, enter, clear,
    output value, value_valid, most_digit, least_digit, digit_count, err
  );
endinterface

// File: rtl/wait_time_entry_bcd2_to_bin.sv
// Combinational two-digit BCD to binary converter.
//   tens, ones : BCD digits (0..9 each)
//   bin        : tens*10 + ones, 0..99
module bcd2_to_bin (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] bin
);

  logic [6:0] tens7_s;

  // tens*10 built from shifts: 8t + 2t; 99 fits in 7 bits so no overflow.
  assign tens7_s = {3'b000, tens};
  assign bin     = (tens7_s << 3) + (tens7_s << 1) + {3'b000, ones};

endmodule

// File: rtl/wait_time_entry.sv
// Teller keypad entry: collects up to two decimal digits and commits them
// as a binary waiting time for the queue controller.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : keypad strobes in, committed value / echo / status out
// A commit is captured on the edge that samples enter and published on
// the following edge, so value/value_valid appear one cycle after enter.
module wait_time_entry
  import wait_time_entry_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  wait_time_entry_if.slave   bus
);

  state_e           state_r, state_s;
  logic [3:0]       most_r, most_s;
  logic [3:0]       least_r, least_s;
  logic [1:0]       count_r, count_s;
  logic             err_r, err_s;
  logic             commit_s;
  logic             pend_r;
  logic [6:0]       pend_bin_r;
  logic [6:0]       bin_s;
  logic [WIDTH-1:0] value_r;
  logic             value_valid_r;

  bcd2_to_bin u_bcd2_to_bin (
    .tens (most_r),
    .ones (least_r),
    .bin  (bin_s)
  );

  // Next-state and next-digit logic; priority clear > enter > digit_valid.
  always_comb begin
    state_s  = state_r;
    most_s   = most_r;
    least_s  = least_r;
    count_s  = count_r;
    err_s    = err_r;
    commit_s = 1'b0;
    if (bus.clear) begin
      state_s = ST_IDLE;
      most_s  = 4'd0;
      least_s = 4'd0;
      count_s = 2'd0;
      err_s   = 1'b0;
    end else if (bus.enter) begin
      case (state_r)
        ST_ONE, ST_TWO: begin
          commit_s = 1'b1;
          state_s  = ST_IDLE;
          most_s   = 4'd0;
          least_s  = 4'd0;
          count_s  = 2'd0;
        end
        default: begin
          // Empty entry or error: nothing to commit.
        end
      endcase
    end else if (bus.digit_valid) begin
      if (state_r == ST_ERR) begin
        // Locked until clear or reset.
      end else if (!is_bcd(bus.digit)) begin
        state_s = ST_ERR;
        err_s   = 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            least_s = bus.digit;
            most_s  = 4'd0;
            count_s = 2'd1;
            state_s = ST_ONE;
          end
          ST_ONE: begin
            most_s  = least_r;
            least_s = bus.digit;
            count_s = 2'(MAX_DIGITS);
            state_s = ST_TWO;
          end
          ST_TWO: begin
            // Third digit overflows the entry; keep the echo as typed.
            state_s = ST_ERR;
            err_s   = 1'b1;
          end
          default: begin
            state_s = ST_ERR;
            err_s   = 1'b1;
          end
        endcase
      end
    end else begin
      // No strobe: hold.
    end
  end

  // State, digit and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      most_r        <= 4'd0;
      least_r       <= 4'd0;
      count_r       <= 2'd0;
      err_r         <= 1'b0;
      pend_r        <= 1'b0;
      pend_bin_r    <= 7'd0;
      value_r       <= WIDTH'(RESET_VALUE);
      value_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      most_r        <= most_s;
      least_r       <= least_s;
      count_r       <= count_s;
      err_r         <= err_s;
      pend_r        <= commit_s;
      pend_bin_r    <= bin_s;
      value_valid_r <= pend_r;
      if (pend_r) begin
        value_r <= WIDTH'(pend_bin_r);
      end else begin
        value_r <= value_r;
      end
    end
  end

  assign bus.value       = value_r;
  assign bus.value_valid = value_valid_r;
  assign bus.most_digit  = most_r;
  assign bus.least_digit = least_r;
  assign bus.digit_count = count_r;
  assign bus.err         = err_r;

endmodule

// File: tb/tb_wait_time_entry.sv
// Directed bench for wait_time_entry: expected commits are queued when
// enter is driven and consumed when value_valid pulses.
module tb_wait_time_entry;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   pulses;
  logic prev_vv;
  logic [7:0] sb[$];

  wait_time_entry_if #(.WIDTH(8)) bus ();

  wait_time_entry #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and score any commit pulse.
  task automatic cyc();
    logic       avail;
    logic [7:0] e;
    @(posedge clk);
    #1;
    chk("vv_back_to_back", {31'd0, prev_vv & bus.value_valid}, 32'd0);
    if (bus.value_valid === 1'b1) begin
      avail = (sb.size() > 0);
      chk("pulse_expected", {31'd0, avail}, 32'd1);
      if (avail) begin
        e = sb.pop_front();
        chk("value", {24'd0, bus.value}, {24'd0, e});
      end
      pulses++;
    end
    prev_vv = bus.value_valid;
  endtask

  task automatic key(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    cyc();
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
  endtask

  task automatic press_enter();
    bus.enter = 1'b1;
    cyc();
    bus.enter = 1'b0;
  endtask

  task automatic press_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
  endtask

  task automatic chk_echo(input string tag, input logic [3:0] m, input logic [3:0] l,
                          input logic [1:0] c, input logic e);
    chk({tag, "_most"},  {28'd0, bus.most_digit},  {28'd0, m});
    chk({tag, "_least"}, {28'd0, bus.least_digit}, {28'd0, l});
    chk({tag, "_count"}, {30'd0, bus.digit_count}, {30'd0, c});
    chk({tag, "_err"},   {31'd0, bus.err},         {31'd0, e});
  endtask

  task automatic drained(input string tag);
    chk({tag, "_drained"}, sb.size(), 32'd0);
  endtask

  initial begin
    int p0;
    n_checks = 0;
    n_fail   = 0;
    pulses   = 0;
    prev_vv  = 1'b0;
    rst_n    = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("rst_value", {24'd0, bus.value}, 32'd0);
    chk("rst_vv", {31'd0, bus.value_valid}, 32'd0);
    chk_echo("rst", 4'd0, 4'd0, 2'd0, 1'b0);

    // 4, 7, enter -> 47
    key(4'd4);
    chk_echo("d4", 4'd0, 4'd4, 2'd1, 1'b0);
    key(4'd7);
    chk_echo("d47", 4'd4, 4'd7, 2'd2, 1'b0);
    sb.push_back(8'h2F);
    press_enter();
    chk_echo("after_enter47", 4'd0, 4'd0, 2'd0, 1'b0);
    chk("vv_not_yet", {31'd0, bus.value_valid}, 32'd0);
    cyc();
    chk("vv_47", {31'd0, bus.value_valid}, 32'd1);
    cyc();
    chk("vv_47_drop", {31'd0, bus.value_valid}, 32'd0);
    drained("e47");

    // 5, enter -> 5; enter in IDLE ignored
    key(4'd5);
    sb.push_back(8'd5);
    press_enter();
    cyc();
    cyc();
    drained("e5");
    p0 = pulses;
    press_enter();
    cyc();
    cyc();
    chk("idle_enter_pulses", pulses, p0);
    chk("idle_enter_value", {24'd0, bus.value}, 32'd5);

    // 9, 9, 3 -> overflow error; enter ignored; clear; 1, 2 -> 12
    key(4'd9);
    key(4'd9);
    key(4'd3);
    chk_echo("ovf", 4'd9, 4'd9, 2'd2, 1'b1);
    press_enter();
    cyc();
    cyc();
    chk("err_enter_value", {24'd0, bus.value}, 32'd5);
    key(4'd1);
    chk_echo("err_digit", 4'd9, 4'd9, 2'd2, 1'b1);
    press_clear();
    chk_echo("clear", 4'd0, 4'd0, 2'd0, 1'b0);
    key(4'd1);
    key(4'd2);
    sb.push_back(8'd12);
    press_enter();
    cyc();
    cyc();
    drained("e12");

    // illegal code in IDLE
    key(4'hA);
    chk_echo("bad_digit", 4'd0, 4'd0, 2'd0, 1'b1);
    p0 = pulses;
    press_enter();
    cyc();
    cyc();
    chk("bad_enter_pulses", pulses, p0);
    chk("bad_enter_value", {24'd0, bus.value}, 32'd12);
    press_clear();

    // enter and digit together in ONE -> commit 6, digit dropped
    key(4'd6);
    bus.digit_valid = 1'b1;
    bus.digit       = 4'd2;
    sb.push_back(8'd6);
    press_enter();
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    chk_echo("enter_wins", 4'd0, 4'd0, 2'd0, 1'b0);
    cyc();
    cyc();
    drained("e6");
    chk("value_6", {24'd0, bus.value}, 32'd6);

    // clear beats enter in TWO
    key(4'd1);
    key(4'd3);
    p0 = pulses;
    bus.clear = 1'b1;
    press_enter();
    bus.clear = 1'b0;
    chk_echo("clear_wins", 4'd0, 4'd0, 2'd0, 1'b0);
    cyc();
    cyc();
    chk("clear_wins_pulses", pulses, p0);
    chk("clear_wins_value", {24'd0, bus.value}, 32'd6);

    // reset mid-entry
    key(4'd3);
    key(4'd8);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("midrst_value", {24'd0, bus.value}, 32'd0);
    chk("midrst_vv", {31'd0, bus.value_valid}, 32'd0);
    chk_echo("midrst", 4'd0, 4'd0, 2'd0, 1'b0);
    p0 = pulses;
    press_enter();
    cyc();
    cyc();
    chk("midrst_enter_pulses", pulses, p0);

    // 0, 0, enter -> value 0 with a pulse
    key(4'd0);
    key(4'd0);
    chk_echo("d00", 4'd0, 4'd0, 2'd2, 1'b0);
    p0 = pulses;
    sb.push_back(8'd0);
    press_enter();
    cyc();
    cyc();
    chk("e00_pulses", pulses, p0 + 1);
    drained("e00");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wait_time_entry.md
Name: wait_time_entry

Overview:
Teller-side keypad entry block that accepts decimal digits one at a time and packs them into an 8-bit binary waiting time.
It performs the inverse of the binary-to-two-digit-BCD display path.
The committed value feeds the queue controller's wtime register.
The current digits are echoed as two BCD nibbles so the existing 7-segment decoders can show the entry as it is typed.

Parameters:
WIDTH, 8, width of the committed binary value; must be >= 7, since 99 is the maximum.
MAX_DIGITS, 2, fixed number of decimal digits accepted; not overridable in this revision.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, synchronous, active-low
digit_valid  input  1  one-cycle strobe: digit is valid this cycle
digit  input  4  BCD digit from keypad encoder
enter  input  1  one-cycle strobe: commit current entry
clear  input  1  one-cycle strobe: abort entry and clear error
value  output  WIDTH  last committed binary value
value_valid  output  1  one-cycle pulse when value updates
most_digit  output  4  echo of tens digit (BCD)
least_digit  output  4  echo of ones digit (BCD)
digit_count  output  2  digits currently held (0..2)
err  output  1  sticky error flag

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - rst_n is synchronous and active-low.
  - While rst_n = 0 at an edge: state = IDLE, value = 0, value_valid = 0, most_digit = 0, least_digit = 0, digit_count = 0, err = 0.
  - Reset mid-entry discards the partial digits; no value_valid pulse.
- FSM states: IDLE (0 digits), ONE (1 digit), TWO (2 digits), ERR.
- Input priority per cycle: rst_n > clear > enter > digit_valid.
- clear, from any state: go to IDLE, zero both echo digits, digit_count = 0, err = 0. value is kept. No pulse.
- digit_valid with digit > 9, in any state except ERR: go to ERR, err = 1. Echo digits unchanged.
- IDLE + valid digit d: least_digit = d, most_digit = 0, go to ONE.
- ONE + valid digit d: most_digit = least_digit, least_digit = d, go to TWO.
- TWO + valid digit: overflow. Go to ERR, err = 1, digits unchanged.
- enter in ONE or TWO:
  - Next edge: value = most_digit*10 + least_digit, zero-extended to WIDTH; value_valid = 1 for exactly that cycle.
  - Then go to IDLE with echo digits zeroed and digit_count = 0.
  - Latency: enter sampled at edge N, value and value_valid visible after edge N+1.
- enter in IDLE: ignored. No pulse, value kept. An empty entry never commits.
- enter in ERR: ignored.
- ERR: digit_valid and enter are ignored. Only clear or reset exits.
- Simultaneous enter and digit_valid in ONE/TWO: enter wins, the digit is dropped, and the commit uses the digits held before this cycle.
- Arithmetic:
  - *10 is implemented as (t<<3)+(t<<1) on 7 bits.
  - The result is at most 99, so no saturation is needed.
  - Upper WIDTH-7 bits are 0.
- value_valid is never high two consecutive cycles.
- digit_count tracks state: IDLE 0, ONE 1, TWO 2, ERR holds the count at the time of error.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE, ONE, TWO, ERR)
  - BCD_MAX = 9
  - MAX_DIGITS = 2
  - the RESET_VALUE constant
- One natural sub-module: bcd2_to_bin, a combinational converter from {tens, ones} to 7-bit binary. It is reusable wherever two BCD digits must be converted back to binary.
- The FSM, digit registers and output register stay in wait_time_entry.

Test Plan:
- Reset, then digits 4, 7, then enter -> one cycle after enter: value = 47 (0x2F), value_valid pulses for 1 cycle, digit_count = 0, echoes = 0.
- Digit 5, then enter -> value = 5. Then enter alone in IDLE -> no pulse, value stays 5.
- Digits 9, 9, 3 -> err = 1 after the third digit. enter ignored (value unchanged). clear -> err = 0, IDLE. Then 1, 2, enter -> value = 12.
- Digit 0xA in IDLE -> err = 1, digit_count = 0. enter -> no pulse.
- Digit 6, then in the same cycle digit_valid = 1 (digit 2) and enter = 1 -> value = 6, digit 2 discarded. In TWO with clear and enter together -> clear wins, no pulse.
- Digits 3, 8, then rst_n = 0 for one cycle before enter -> all outputs 0, a later enter gives no pulse. Separately, entry 00 + enter -> value = 0 with a value_valid pulse.
